// File: rtl/binary_source_pkg.sv
// Shared types and helpers for the binary_source stimulus block.
package binary_source_pkg;

  // Button FSM states; REPEAT is reachable only with BINARY_SOURCE_AUTO_STEP_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_t;

  // Number of flops in every input synchronizer chain
  localparam int SYNC_STAGES = 2;

  // Bits needed for a counter that runs 0 .. cycles-1 (never narrower than 1)
  function automatic int cntWidth(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes one raw active-low button, inverts it to pressed-high,
// debounces the level and emits a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);
  import binary_source_pkg::*;

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressedSync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;

  // Synchronizer chain; resets to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign pressedSync = ~sync_q[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; accept the new level on the last one
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (pressedSync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = pressedSync;
        press_d = pressedSync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/binary_source.sv
// Board stimulus source: synchronized switches plus debounced step/load
// buttons drive a registered WIDTH-bit value with a one-cycle update pulse.
// Optional macro BINARY_SOURCE_AUTO_STEP_EN adds auto-repeat while step is held.
module binary_source #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             btn_step_n,
  input  logic             btn_load_n,
  output logic [WIDTH-1:0] binary_out,
  output logic             update
);
  import binary_source_pkg::*;

  if (WIDTH < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_paramCheck
    $error("binary_source: all parameters must be at least 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] swSync_q;
  logic [WIDTH-1:0]                  swSync;
  logic                              stepLevel, stepPress;
  logic                              loadLevel, loadPress;
  btn_state_t                        state_q, state_d;
  logic [WIDTH-1:0]                  value_q, value_d;
  logic                              update_q, update_d;

`ifdef BINARY_SOURCE_AUTO_STEP_EN
  localparam int HCW = cntWidth(HOLD_CYCLES);
  localparam int RCW = cntWidth(REPEAT_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST   = HCW'(HOLD_CYCLES - 1);
  localparam logic [RCW-1:0] REPEAT_LAST = RCW'(REPEAT_CYCLES - 1);

  logic [HCW-1:0] holdCnt_q, holdCnt_d;
  logic [RCW-1:0] repeatCnt_q, repeatCnt_d;
  logic           viaStep_q, viaStep_d;
`endif

  // Switch synchronizer; switches reset to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swSync_q <= '0;
    end else begin
      swSync_q <= {swSync_q[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign swSync = swSync_q[SYNC_STAGES-1];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepBtn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_step_n),
    .level (stepLevel),
    .press (stepPress)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loadBtn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_load_n),
    .level (loadLevel),
    .press (loadPress)
  );

  // Button FSM: accept one event from IDLE, then wait for both buttons released
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    update_d = 1'b0;
`ifdef BINARY_SOURCE_AUTO_STEP_EN
    holdCnt_d   = holdCnt_q;
    repeatCnt_d = repeatCnt_q;
    viaStep_d   = viaStep_q;
`endif
    case (state_q)
      IDLE: begin
        if (loadPress) begin
          value_d  = swSync;
          update_d = 1'b1;
          state_d  = PRESSED;
`ifdef BINARY_SOURCE_AUTO_STEP_EN
          viaStep_d = 1'b0;
`endif
        end else if (stepPress) begin
          value_d  = value_q + WIDTH'(1);
          update_d = 1'b1;
          state_d  = PRESSED;
`ifdef BINARY_SOURCE_AUTO_STEP_EN
          viaStep_d = 1'b1;
          holdCnt_d = '0;
`endif
        end
      end
      PRESSED: begin
        if (!stepLevel && !loadLevel) begin
          state_d = IDLE;
        end
`ifdef BINARY_SOURCE_AUTO_STEP_EN
        else if (viaStep_q && stepLevel) begin
          if (holdCnt_q == HOLD_LAST) begin
            value_d     = value_q + WIDTH'(1);
            update_d    = 1'b1;
            state_d     = REPEAT;
            repeatCnt_d = '0;
          end else begin
            holdCnt_d = holdCnt_q + HCW'(1);
          end
        end else begin
          viaStep_d = 1'b0;
        end
`endif
      end
`ifdef BINARY_SOURCE_AUTO_STEP_EN
      REPEAT: begin
        if (!stepLevel) begin
          state_d = IDLE;
        end else if (repeatCnt_q == REPEAT_LAST) begin
          value_d     = value_q + WIDTH'(1);
          update_d    = 1'b1;
          repeatCnt_d = '0;
        end else begin
          repeatCnt_d = repeatCnt_q + RCW'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, value and update registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      value_q  <= '0;
      update_q <= 1'b0;
`ifdef BINARY_SOURCE_AUTO_STEP_EN
      holdCnt_q   <= '0;
      repeatCnt_q <= '0;
      viaStep_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      update_q <= update_d;
`ifdef BINARY_SOURCE_AUTO_STEP_EN
      holdCnt_q   <= holdCnt_d;
      repeatCnt_q <= repeatCnt_d;
      viaStep_q   <= viaStep_d;
`endif
    end
  end

  assign binary_out = value_q;
  assign update     = update_q;

endmodule
